// File: rtl/pad_streamer.sv
// ---------------------------------------------------------------------------
// pad_streamer
//
// Purpose:
//   Upstream feeder for conv_top. Takes an unpadded raster of activation beats
//   over a valid/ready stream and emits the raster with a one-pixel zero
//   border on all four sides, cfg_ci_groups beats per pixel position.
//   Scan order: grp innermost, then col, then row.
//
// Optional feature (macro PAD_STREAMER_FLUSH_EN):
//   When defined, the final padded beat is followed by 2*(W+2)*G+4 zero beats
//   that drain the conv_top line buffers before done is raised.
//   When undefined, the FLUSH state and its counter do not exist.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_img_width      unpadded width W   (latched on accepted start)
//   cfg_img_height     unpadded height H  (latched on accepted start)
//   cfg_ci_groups      beats per pixel position (latched on accepted start)
//   start              begin a frame; only sampled in IDLE while not busy
//   busy               frame in progress
//   done               one-cycle pulse after the final output beat
//   err_last           sticky: s_last misplaced; cleared by reset or start
//   s_data/s_valid/s_ready/s_last   input stream
//   m_data/m_valid/m_last           registered output stream (pixel_in*)
//   dbg_state          current FSM state, for checkers
//
// Handshake: an input beat transfers on a rising edge where s_valid and
// s_ready are both high. s_ready depends only on state and counters (never on
// s_valid); it is high exactly at interior positions during SCAN. The output
// side has no back-pressure: m_valid marks a beat on every cycle it is high.
// ---------------------------------------------------------------------------
module pad_streamer #(
    parameter int DATA_W = 64,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIM_W-1:0]  cfg_img_width,
    input  logic [DIM_W-1:0]  cfg_img_height,
    input  logic [9:0]        cfg_ci_groups,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_last,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic [1:0]        dbg_state
);

`ifdef PAD_STREAMER_FLUSH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;
    localparam int FL_W = DIM_W + 12;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif

    state_t           state;
    logic [DIM_W-1:0] w_q, h_q;
    logic [9:0]       g_q;
    logic [DIM_W-1:0] row, col;
    logic [9:0]       grp;

    logic [DIM_W-1:0] w_end, h_end;
    logic [9:0]       g_end;
    logic             is_pad, grp_wrap, col_wrap, at_final, at_last_in;
    logic             accept, advance, degenerate;

    assign w_end = w_q + 1'b1;
    assign h_end = h_q + 1'b1;
    assign g_end = g_q - 1'b1;

    assign is_pad     = (row == '0) || (row == h_end) || (col == '0) || (col == w_end);
    assign grp_wrap   = (grp == g_end);
    assign col_wrap   = (col == w_end);
    assign at_final   = (row == h_end) && col_wrap && grp_wrap;
    // The last unpadded beat sits at the bottom-right interior pixel, last group.
    assign at_last_in = (row == h_q) && (col == w_q) && grp_wrap;

    assign s_ready = (state == SCAN) && !is_pad;
    assign accept  = s_valid && s_ready;
    // Pad positions never stall; interior positions wait for input.
    assign advance = (state == SCAN) && (is_pad || s_valid);

    assign degenerate = (cfg_img_width == '0) || (cfg_img_height == '0) ||
                        (cfg_ci_groups == '0);
    assign dbg_state  = state;

`ifdef PAD_STREAMER_FLUSH_EN
    logic [FL_W-1:0] fl_cnt, fl_end, fl_len_c;
    // Index of the final flush beat: 2*(W+2)*G + 4 beats, counted from 0.
    assign fl_len_c = (((FL_W'(cfg_img_width) + FL_W'(2)) * FL_W'(cfg_ci_groups)) << 1)
                      + FL_W'(3);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            g_q      <= '0;
            row      <= '0;
            col      <= '0;
            grp      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_last <= 1'b0;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
`ifdef PAD_STREAMER_FLUSH_EN
            fl_cnt   <= '0;
            fl_end   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    m_data  <= '0;
                    if (busy) begin
                        // Wrap-up cycle after the final output beat.
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (start) begin
                        w_q      <= cfg_img_width;
                        h_q      <= cfg_img_height;
                        g_q      <= cfg_ci_groups;
                        row      <= '0;
                        col      <= '0;
                        grp      <= '0;
                        err_last <= 1'b0;
`ifdef PAD_STREAMER_FLUSH_EN
                        fl_cnt   <= '0;
                        fl_end   <= fl_len_c;
`endif
                        if (degenerate) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= SCAN;
                        end
                    end
                end

                SCAN: begin
                    m_valid <= advance;
                    m_last  <= advance && at_final;
                    m_data  <= accept ? s_data : '0;
                    if (accept && (s_last != at_last_in)) begin
                        err_last <= 1'b1;
                    end
                    if (advance) begin
                        if (grp_wrap) begin
                            grp <= '0;
                            if (col_wrap) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            grp <= grp + 1'b1;
                        end
                        if (at_final) begin
`ifdef PAD_STREAMER_FLUSH_EN
                            state <= FLUSH;
`else
                            state <= IDLE;
`endif
                        end
                    end
                end

`ifdef PAD_STREAMER_FLUSH_EN
                FLUSH: begin
                    m_valid <= 1'b1;
                    m_last  <= 1'b0;
                    m_data  <= '0;
                    if (fl_cnt == fl_end) begin
                        state <= IDLE;
                    end else begin
                        fl_cnt <= fl_cnt + 1'b1;
                    end
                end
`endif

                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    m_data  <= '0;
                end
            endcase
        end
    end

endmodule
